// File: rtl/servo_cmd_ramp_if.sv
// Command channel into the servo ramp block: a pulse-width request
// carried over a valid/ready handshake.
interface servo_cmd_ramp_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_width;

   modport master (
      output cmd_valid,
      output cmd_width,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_width,
      output cmd_ready
   );
endinterface

// File: rtl/servo_cmd_ramp.sv
// Servo command ramp: clamps accepted pulse-width commands and slews the PWM
// width toward the target by at most STEP ticks, once per servo frame.
module servo_cmd_ramp #(
   parameter int FRAME_CYCLES = 2049024,
   parameter int MIN_WIDTH    = 50,
   parameter int MAX_WIDTH    = 250,
   parameter int RESET_WIDTH  = 150,
   parameter int STEP         = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   servo_cmd_ramp_if.slave       cmd,
   output logic [10:0]           width_out,
   output logic                  at_target,
   output logic                  frame_tick
);

   localparam int              CW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [10:0]     MIN_W    = 11'(MIN_WIDTH);
   localparam logic [10:0]     MAX_W    = 11'(MAX_WIDTH);
   localparam logic [10:0]     RST_W    = 11'(RESET_WIDTH);
   localparam logic [10:0]     STEP_W11 = 11'(STEP);
   localparam logic [11:0]     STEP_W12 = 12'(STEP);

   logic [CW-1:0]      cnt_r;
   logic [CW-1:0]      cnt_nxt_s;
   logic               tick_r;
   logic [10:0]        target_r;
   logic [10:0]        target_nxt_s;
   logic [10:0]        width_r;
   logic [10:0]        width_nxt_s;
   logic               pend_valid_r;
   logic               pend_valid_nxt_s;
   logic [10:0]        pend_r;
   logic [10:0]        pend_nxt_s;
   logic               ready_r;
   logic               at_target_r;
   logic               xfer_s;
   logic [10:0]        next_target_s;
   logic signed [11:0] diff_s;
   logic [11:0]        mag_s;

   function automatic logic [10:0] clamp_width(input logic [10:0] w);
      logic [10:0] r;
      if (w < MIN_W) begin
         r = MIN_W;
      end else if (w > MAX_W) begin
         r = MAX_W;
      end else begin
         r = w;
      end
      return r;
   endfunction

   // Next-state logic for frame counter, pending buffer, target and ramped width.
   always_comb begin
      cnt_nxt_s     = (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CW'(1'b1);
      xfer_s        = cmd.cmd_valid & ready_r;
      next_target_s = pend_valid_r ? pend_r : target_r;
      diff_s        = $signed({1'b0, next_target_s}) - $signed({1'b0, width_r});
      mag_s         = diff_s[11] ? $unsigned(-diff_s) : $unsigned(diff_s);

      if (tick_r) begin
         target_nxt_s = next_target_s;
         if ((STEP == 0) || (mag_s <= STEP_W12)) begin
            width_nxt_s = next_target_s;
         end else if (diff_s[11]) begin
            width_nxt_s = width_r - STEP_W11;
         end else begin
            width_nxt_s = width_r + STEP_W11;
         end
      end else begin
         target_nxt_s = target_r;
         width_nxt_s  = width_r;
      end

      // A transfer implies the buffer was empty, so a same-cycle tick cannot consume it.
      if (xfer_s) begin
         pend_valid_nxt_s = 1'b1;
         pend_nxt_s       = clamp_width(cmd.cmd_width);
      end else if (tick_r) begin
         pend_valid_nxt_s = 1'b0;
         pend_nxt_s       = pend_r;
      end else begin
         pend_valid_nxt_s = pend_valid_r;
         pend_nxt_s       = pend_r;
      end
   end

   // State and registered-output update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r        <= {CW{1'b0}};
         tick_r       <= 1'b0;
         target_r     <= RST_W;
         width_r      <= RST_W;
         pend_valid_r <= 1'b0;
         pend_r       <= RST_W;
         ready_r      <= 1'b1;
         at_target_r  <= 1'b1;
      end else begin
         cnt_r        <= cnt_nxt_s;
         tick_r       <= (cnt_nxt_s == CNT_LAST);
         target_r     <= target_nxt_s;
         width_r      <= width_nxt_s;
         pend_valid_r <= pend_valid_nxt_s;
         pend_r       <= pend_nxt_s;
         ready_r      <= ~pend_valid_nxt_s;
         at_target_r  <= (width_nxt_s == target_nxt_s) & ~pend_valid_nxt_s;
      end
   end

   assign cmd.cmd_ready = ready_r;
   assign width_out     = width_r;
   assign at_target     = at_target_r;
   assign frame_tick    = tick_r;

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Bench for servo_cmd_ramp: two instances (STEP=5 and STEP=0) share one
// command stream and are compared every cycle against a frame-level model.
module tb_servo_cmd_ramp;
   localparam int FC = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [10:0] cmd_width = 11'd0;
   logic [10:0] wo_a, wo_b;
   logic        at_a, at_b, tk_a, tk_b;

   int total = 0;
   int bad = 0;

   servo_cmd_ramp_if if_a ();
   servo_cmd_ramp_if if_b ();

   assign if_a.cmd_valid = cmd_valid;
   assign if_a.cmd_width = cmd_width;
   assign if_b.cmd_valid = cmd_valid;
   assign if_b.cmd_width = cmd_width;

   servo_cmd_ramp #(.FRAME_CYCLES(FC), .STEP(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd(if_a.slave),
      .width_out(wo_a), .at_target(at_a), .frame_tick(tk_a)
   );

   servo_cmd_ramp #(.FRAME_CYCLES(FC), .STEP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd(if_b.slave),
      .width_out(wo_b), .at_target(at_b), .frame_tick(tk_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: one pending slot, target, and width per step size.
   bit m_on = 1'b0;
   int m_cyc;
   bit m_pv;
   int m_pend;
   int m_tgt;
   int m_w[2];

   function automatic int clampi(input int w);
      return (w < 50) ? 50 : ((w > 250) ? 250 : w);
   endfunction

   function automatic int toward(input int w, input int t, input int s);
      int d;
      d = t - w;
      if (s == 0 || (d <= s && d >= -s)) return t;
      return (d > 0) ? w + s : w - s;
   endfunction

   always @(posedge clk) begin : model
      bit tick;
      bit xfer;
      int nt;
      if (!rst_n) begin
         m_on   <= 1'b1;
         m_cyc  <= 0;
         m_pv   <= 1'b0;
         m_pend <= 0;
         m_tgt  <= 150;
         m_w[0] <= 150;
         m_w[1] <= 150;
      end else if (m_on) begin
         tick = ((m_cyc % FC) == FC - 1);
         xfer = cmd_valid && !m_pv;
         m_cyc <= m_cyc + 1;
         if (tick) begin
            nt = m_pv ? m_pend : m_tgt;
            m_tgt  <= nt;
            m_w[0] <= toward(m_w[0], nt, 5);
            m_w[1] <= toward(m_w[1], nt, 0);
         end
         if (xfer) begin
            m_pv   <= 1'b1;
            m_pend <= clampi(int'(cmd_width));
         end else if (tick) begin
            m_pv <= 1'b0;
         end
      end
   end

   task automatic cmp_dut(input int idx, input int w, input int at, input int rd, input int tk);
      chk($sformatf("width[%0d]", idx), w, m_w[idx]);
      chk($sformatf("at_target[%0d]", idx), at, int'(m_w[idx] == m_tgt && !m_pv));
      chk($sformatf("cmd_ready[%0d]", idx), rd, int'(!m_pv));
      chk($sformatf("frame_tick[%0d]", idx), tk, int'((m_cyc % FC) == FC - 1));
      chk($sformatf("range[%0d]", idx), int'(w >= 50 && w <= 250), 1);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_on) begin
         cmp_dut(0, int'(wo_a), int'(at_a), int'(if_a.cmd_ready), int'(tk_a));
         cmp_dut(1, int'(wo_b), int'(at_b), int'(if_b.cmd_ready), int'(tk_b));
      end
   end

   task automatic send(input int w);
      bit done;
      done = 1'b0;
      cmd_valid = 1'b1;
      cmd_width = 11'(w);
      for (int i = 0; i < 200 && !done; i++) begin
         if (if_a.cmd_ready) begin
            @(posedge clk);
            done = 1'b1;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic send_on_tick(input int w);
      int k;
      k = 0;
      while (!tk_a && k < 4 * FC) begin
         @(negedge clk);
         k++;
      end
      if (!tk_a) chk("tick_wait_timeout", 0, 1);
      cmd_valid = 1'b1;
      cmd_width = 11'(w);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      int seen;
      int cyc;
      seen = 0;
      cyc = 0;
      while (seen < n && cyc < FC * n + 40) begin
         @(negedge clk);
         cyc++;
         if (tk_a) seen++;
      end
      if (seen < n) chk("tick_timeout", seen, n);
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_width", int'(wo_a), 150);
      chk("reset_ready", int'(if_a.cmd_ready), 1);
      chk("reset_at_target", int'(at_a), 1);

      // Idle frames: nothing moves.
      for (int i = 0; i < 3; i++) begin
         wait_ticks(1);
         chk("idle_width", int'(wo_a), 150);
      end

      // Ramp up by 5 per frame.
      send(175);
      chk("busy_ready", int'(if_a.cmd_ready), 0);
      for (int i = 1; i <= 5; i++) begin
         wait_ticks(1);
         chk("ramp175", int'(wo_a), 150 + 5 * i);
      end
      chk("ramp175_at_target", int'(at_a), 1);
      chk("jump175", int'(wo_b), 175);

      // Clamping at both ends.
      send(2000);
      wait_ticks(1);
      chk("clamp_hi_step", int'(wo_a), 180);
      chk("clamp_hi_jump", int'(wo_b), 250);
      wait_ticks(14);
      chk("clamp_hi_final", int'(wo_a), 250);
      send(10);
      wait_ticks(40);
      chk("clamp_lo_final", int'(wo_a), 50);
      chk("clamp_lo_jump", int'(wo_b), 50);

      // Partial step and direct jump.
      send(150);
      wait_ticks(20);
      chk("back150", int'(wo_a), 150);
      send(152);
      wait_ticks(1);
      chk("partial_step", int'(wo_a), 152);
      send(240);
      wait_ticks(1);
      chk("step0_jump", int'(wo_b), 240);
      chk("step5_after240", int'(wo_a), 157);

      // Backpressure and a command accepted on the tick cycle.
      send(200);
      send(100);
      chk("bp_width", int'(wo_a), 162);
      chk("bp_ready", int'(if_a.cmd_ready), 0);
      wait_ticks(1);
      chk("bp_applied", int'(wo_a), 157);
      chk("bp_applied_b", int'(wo_b), 100);
      send_on_tick(120);
      chk("ontick_width", int'(wo_a), 152);
      chk("ontick_ready", int'(if_a.cmd_ready), 0);
      wait_ticks(1);
      chk("ontick_applied", int'(wo_a), 147);
      chk("ontick_applied_b", int'(wo_b), 120);

      // Reset mid-ramp with a command pending.
      send(150);
      wait_ticks(1);
      chk("pre_ramp", int'(wo_a), 150);
      send(250);
      wait_ticks(6);
      chk("mid_ramp", int'(wo_a), 180);
      send(60);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_width", int'(wo_a), 150);
      chk("rst_width_b", int'(wo_b), 150);
      chk("rst_at_target", int'(at_a), 1);
      chk("rst_ready", int'(if_a.cmd_ready), 1);
      k = 0;
      while (!tk_a && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("rst_tick_distance", k, FC - 1);
      wait_ticks(2);
      chk("discarded_cmd", int'(wo_a), 150);
      chk("discarded_cmd_b", int'(wo_b), 150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
